act_lut_scheduler: RTL and testbench

ACT_LUT_SCHEDULER -- requirements
Module: act_lut_scheduler

---
 rtl/act_sched_pkg.sv | 28 ++
 rtl/act_interp.sv | 34 +++
 rtl/act_lut_scheduler.sv | 149 ++++++++++++++
 tb/tb_act_lut_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/act_sched_pkg.sv
// Shared types, default widths and the saturation helper for act_lut_scheduler.
package act_sched_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int IN_W_DEF   = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CALC,
        HOLD
    } state_e;

    // Clamp a wide signed value into the signed range of a width-bit result.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                    input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/act_interp.sv
// Combinational linear interpolation between two adjacent activation LUT entries.
module act_interp
    import act_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = IN_W_DEF - ADDR_W_DEF
) (
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] nxt,
    input  logic        [FRAC_W-1:0] frac,
    output logic signed [DATA_W-1:0] result
);

    localparam int PROD_W = DATA_W + FRAC_W + 2;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;
    logic signed [31:0]       sum;

    always_comb begin
        diff     = {nxt[DATA_W-1], nxt} - {base[DATA_W-1], base};
        diff_ext = PROD_W'(diff);
        frac_ext = PROD_W'({1'b0, frac});
        prod     = diff_ext * frac_ext;
        // Arithmetic shift floors toward minus infinity for falling segments.
        step     = prod >>> FRAC_W;
        sum      = 32'(step) + 32'(base);
        result   = DATA_W'(saturate(sum, DATA_W));
    end

endmodule

// File: rtl/act_lut_scheduler.sv
// Round-robin scheduler sharing one external activation LUT among N_REQ neurons.
// Build option: define ACT_SCHED_INTERP_EN to enable the interpolating CALC stage.
module act_lut_scheduler
    import act_sched_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*IN_W-1:0]      x_in,
    output logic [N_REQ-1:0]           gnt,
    output logic [ADDR_W-1:0]          lut_addr,
    input  logic signed [DATA_W-1:0]   lut_base,
    input  logic signed [DATA_W-1:0]   lut_next,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    input  logic                       out_ready
);

    localparam int FRAC_W = IN_W - ADDR_W;
    localparam int ID_W   = $clog2(N_REQ);

    state_e                    state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [IN_W-1:0]           x_q, x_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;

    logic                      found;
    logic [ID_W-1:0]           gnt_idx;

`ifdef ACT_SCHED_INTERP_EN
    logic signed [DATA_W-1:0]  base_q, base_d;
    logic signed [DATA_W-1:0]  next_q, next_d;
    logic signed [DATA_W-1:0]  interp_res;

    act_interp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_interp (
        .base   (base_q),
        .nxt    (next_q),
        .frac   (x_q[FRAC_W-1:0]),
        .result (interp_res)
    );
`else
    logic unused_plain;
    assign unused_plain = ^{lut_next, x_q[FRAC_W-1:0]};
`endif

    // Round-robin search: first requester at or after ptr_q, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int              idx;
            logic [ID_W-1:0] cand;
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        x_d        = x_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        gnt        = '0;
`ifdef ACT_SCHED_INTERP_EN
        base_d     = base_q;
        next_d     = next_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    gnt[gnt_idx] = 1'b1;
                    x_d          = x_in[gnt_idx*IN_W +: IN_W];
                    id_d         = gnt_idx;
                    ptr_d        = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
`ifdef ACT_SCHED_INTERP_EN
                base_d  = lut_base;
                next_d  = lut_next;
                state_d = CALC;
`else
                out_data_d = lut_base;
                state_d    = HOLD;
`endif
            end
`ifdef ACT_SCHED_INTERP_EN
            CALC: begin
                out_data_d = interp_res;
                state_d    = HOLD;
            end
`endif
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            x_q        <= '0;
            id_q       <= '0;
            out_data_q <= '0;
`ifdef ACT_SCHED_INTERP_EN
            base_q     <= '0;
            next_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            x_q        <= x_d;
            id_q       <= id_d;
            out_data_q <= out_data_d;
`ifdef ACT_SCHED_INTERP_EN
            base_q     <= base_d;
            next_q     <= next_d;
`endif
        end
    end

    // The address comes straight from the latched input, so it holds while idle.
    assign lut_addr  = x_q[IN_W-1:FRAC_W];
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_act_lut_scheduler.sv
// Directed bench for act_lut_scheduler with a behavioural LUT; expectations
// follow ACT_SCHED_INTERP_EN (interpolated, latency 3) or plain lookup (latency 2).
module tb_act_lut_scheduler;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [31:0]       x_in;
    logic [3:0]        gnt;
    logic [3:0]        lut_addr;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic [1:0]        out_id;
    logic              out_ready;

    int total = 0;
    int bad   = 0;
    int lut_mode = 0;

`ifdef ACT_SCHED_INTERP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    act_lut_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .gnt       (gnt),
        .lut_addr  (lut_addr),
        .lut_base  (lut_base),
        .lut_next  (lut_next),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Mode 0: 16*a for a<8, else 0. Mode 1: alternating +127 / -128 for signed checks.
    function automatic logic signed [7:0] lut_val(input int mode, input int a);
        if (mode == 1) return (a % 2 == 0) ? 8'sd127 : -8'sd128;
        return (a < 8) ? 8'(16 * a) : 8'sd0;
    endfunction

    always_comb begin
        lut_base = lut_val(lut_mode, int'(lut_addr));
        lut_next = lut_val(lut_mode, (lut_addr == 4'd7) ? 7 : (int'(lut_addr) + 1) % 16);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                id;
        int                mode;
        logic [7:0]        x;
        logic signed [7:0] exp_interp;
        logic signed [7:0] exp_plain;
    } vec_t;

    vec_t vecs[10];

    function automatic logic signed [7:0] pick(input vec_t v);
`ifdef ACT_SCHED_INTERP_EN
        return v.exp_interp;
`else
        return v.exp_plain;
`endif
    endfunction

    // Wait (bounded) for out_valid; returns the number of rising edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic txn(input int id, input logic [7:0] x, input logic signed [7:0] exp);
        int n;
        @(negedge clk);
        x_in[id*8 +: 8] = x;
        req = 4'(1 << id);
        #1 check("txn_gnt", 32'(gnt), 32'(1 << id));
        @(posedge clk);
        #1 req = '0;
        wait_valid(n);
        check("txn_latency", 32'(n), 32'(LAT - 1));
        check("txn_data", 32'(out_data), 32'(exp));
        check("txn_id", 32'(out_id), 32'(id));
        @(posedge clk);
        #1 check("txn_accepted", 32'(out_valid), 32'd0);
        check("txn_addr_hold", 32'(lut_addr), 32'(x[7:4]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{0, 0, 8'h25,   8'sd37,   8'sd32};
        vecs[1] = '{1, 0, 8'h70,  8'sd112,  8'sd112};
        vecs[2] = '{2, 0, 8'hF8,    8'sd0,    8'sd0};
        vecs[3] = '{3, 0, 8'h18,   8'sd24,   8'sd16};
        vecs[4] = '{0, 0, 8'h0F,   8'sd15,    8'sd0};
        vecs[5] = '{1, 0, 8'h6C,  8'sd108,   8'sd96};
        vecs[6] = '{2, 0, 8'h8A,    8'sd0,    8'sd0};
        vecs[7] = '{3, 1, 8'h0F, -8'sd113,  8'sd127};
        vecs[8] = '{0, 1, 8'h01,  8'sd111,  8'sd127};
        vecs[9] = '{1, 1, 8'h18,   -8'sd1, -8'sd128};

        rst = 1'b1; req = 4'b0001; x_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_addr", 32'(lut_addr), 32'd0);
        rst = 1'b0;
        req = '0;

        for (int i = 0; i < 10; i++) begin
            lut_mode = vecs[i].mode;
            txn(vecs[i].id, vecs[i].x, pick(vecs[i]));
        end
        lut_mode = 0;

        // Back-pressure: result held, no new grant while out_valid is high.
        out_ready = 1'b0;
        @(negedge clk);
        x_in[15:8] = 8'h25;
        req = 4'b0010;
        #1 check("bp_gnt", 32'(gnt), 32'b0010);
        @(posedge clk);
        #1 req = 4'b1000;
        x_in[31:24] = 8'h70;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'(LAT - 1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(pick(vecs[0])));
            check("bp_no_gnt", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_next_gnt", 32'(gnt), 32'b1000);
        @(posedge clk);
        #1 req = '0;
        wait_valid(n);
        check("bp_next_id", 32'(out_id), 32'd3);
        check("bp_next_data", 32'(out_data), 32'sd112);
        @(posedge clk);
        #1;

        // Reset mid-flight: result discarded, pointer back to 0, held req re-arbitrated.
        @(negedge clk);
        x_in[23:16] = 8'h18;
        req = 4'b0100;
        #1 check("mr_gnt", 32'(gnt), 32'b0100);
        @(posedge clk);
        repeat (LAT - 2) @(posedge clk);
        @(negedge clk);
        check("mr_busy", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1100;
        x_in[31:24] = 8'h25;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);
        check("mr_addr", 32'(lut_addr), 32'd0);
        check("mr_regrant", 32'(gnt), 32'b0100);
        @(posedge clk);
        #1 req = '0;
        wait_valid(n);
        check("mr_latency", 32'(n), 32'(LAT - 1));
        check("mr_id", 32'(out_id), 32'd2);
        check("mr_out", 32'(out_data), 32'(pick(vecs[3])));
        @(posedge clk);
        #1;

        // Round robin with all four requests held from ptr 0.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        x_in = {4{8'h25}};
        req = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (gnt == '0 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("rr_gnt", 32'(gnt), 32'(1 << (g % 4)));
            @(posedge clk);
            #1;
        end
        req = '0;
        wait_valid(n);
        check("rr_last_id", 32'(out_id), 32'd0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
